// File: rtl/ahb_master_mux.sv
// Two-master AHB-lite multiplexer: SoC core (M0) and UART bridge (M1) share one slave bus.
// Ownership follows HMSEL; hand-overs happen only at idle boundaries, through one IDLE gap cycle.
module ahb_master_mux #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit RESET_OWNER = 1'b0
) (
  input  logic              HCLK,
  input  logic              PORESET,
  input  logic [1:0]        HMSEL,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [2:0]        M0_HSIZE,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [2:0]        M1_HSIZE,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [2:0]        S_HSIZE,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADY,
  input  logic              S_HRESP
);

  typedef enum logic [1:0] {
    OWN0 = 2'd0,
    OWN1 = 2'd1,
    NONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam state_t     RESET_STATE = RESET_OWNER ? OWN1 : OWN0;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  state_t state_q, state_d;
  logic   dvalid_q, dvalid_d;
  logic   downer_q, downer_d;
  logic   dwrite_q, dwrite_d;

  logic              req_vld;
  logic              req_sel;
  logic              aowner;
  logic              own_vld;
  logic [ADDR_W-1:0] a_haddr;
  logic [2:0]        a_hsize;
  logic [1:0]        a_htrans;
  logic              a_hwrite;
  logic              a_active;
  logic              a_m0, a_m1;
  logic              d_m0, d_m1;

  // HMSEL 1x means no master wants the bus.
  assign req_vld = ~HMSEL[1];
  assign req_sel = HMSEL[0];

  assign aowner  = (state_q == OWN1);
  assign own_vld = ~PORESET && ((state_q == OWN0) || (state_q == OWN1));

  always_comb begin
    a_haddr  = aowner ? M1_HADDR  : M0_HADDR;
    a_hsize  = aowner ? M1_HSIZE  : M0_HSIZE;
    a_htrans = aowner ? M1_HTRANS : M0_HTRANS;
    a_hwrite = aowner ? M1_HWRITE : M0_HWRITE;
  end

  // HTRANS[1] set means NONSEQ or SEQ, i.e. a real transfer in flight.
  assign a_active = a_htrans[1];

  always_ff @(posedge HCLK or posedge PORESET) begin
    if (PORESET) begin
      state_q  <= RESET_STATE;
      dvalid_q <= 1'b0;
      downer_q <= RESET_OWNER;
      dwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
      dwrite_q <= dwrite_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    S_HADDR  = '0;
    S_HSIZE  = '0;
    S_HTRANS = HTRANS_IDLE;
    S_HWRITE = 1'b0;
    if (own_vld) begin
      S_HADDR  = a_haddr;
      S_HSIZE  = a_hsize;
      S_HTRANS = a_htrans;
      S_HWRITE = a_hwrite;
    end
    case (state_q)
      OWN0, OWN1: begin
        // A granted address phase is never abandoned: leave only on an idle, accepted cycle.
        if (S_HREADY && !a_active && (!req_vld || (req_sel != aowner)))
          state_d = GAP;
      end
      NONE: begin
        if (req_vld && S_HREADY)
          state_d = GAP;
      end
      GAP: begin
        if (!req_vld)
          state_d = NONE;
        else
          state_d = req_sel ? OWN1 : OWN0;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    dvalid_d = dvalid_q;
    downer_d = downer_q;
    dwrite_d = dwrite_q;
    if (S_HREADY) begin
      dvalid_d = own_vld && a_active;
      downer_d = aowner;
      dwrite_d = S_HWRITE;
    end
  end

  assign a_m0 = own_vld && !aowner;
  assign a_m1 = own_vld &&  aowner;
  assign d_m0 = dvalid_q && !downer_q;
  assign d_m1 = dvalid_q &&  downer_q;

  always_comb begin
    S_HWDATA = '0;
    if (dvalid_q && dwrite_q)
      S_HWDATA = downer_q ? M1_HWDATA : M0_HWDATA;

    M0_HRDATA = d_m0 ? S_HRDATA : '0;
    M1_HRDATA = d_m1 ? S_HRDATA : '0;
    M0_HRESP  = d_m0 && S_HRESP;
    M1_HRESP  = d_m1 && S_HRESP;
    M0_HREADY = (a_m0 || d_m0) && S_HREADY;
    M1_HREADY = (a_m1 || d_m1) && S_HREADY;

    // While reset is held the granted master sees a ready bus, the other stays stalled.
    if (PORESET) begin
      M0_HREADY = ~RESET_OWNER;
      M1_HREADY = RESET_OWNER;
    end
  end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Bench for ahb_master_mux: hand-written cycle table, directed corner sequences and
// randomized traffic compared each cycle against a transfer-level ownership model.
module tb_ahb_master_mux;

  localparam int         AW      = 32;
  localparam int         DW      = 32;
  localparam bit         RST_OWN = 1'b0;
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] BUSY    = 2'b01;
  localparam logic [1:0] NSEQ    = 2'b10;
  localparam logic [1:0] SEQ     = 2'b11;

  logic          HCLK = 1'b0;
  logic          PORESET;
  logic [1:0]    HMSEL;
  logic [AW-1:0] haddr  [2];
  logic [2:0]    hsize  [2];
  logic [1:0]    htrans [2];
  logic          hwrite [2];
  logic [DW-1:0] hwdata [2];
  logic [DW-1:0] m0_hrdata, m1_hrdata;
  logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [AW-1:0] s_haddr;
  logic [2:0]    s_hsize;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [DW-1:0] s_hwdata;
  logic [DW-1:0] s_hrdata;
  logic          s_hready;
  logic          s_hresp;

  always #5 HCLK = ~HCLK;

  ahb_master_mux #(.ADDR_W(AW), .DATA_W(DW), .RESET_OWNER(RST_OWN)) dut (
    .HCLK(HCLK), .PORESET(PORESET), .HMSEL(HMSEL),
    .M0_HADDR(haddr[0]), .M0_HSIZE(hsize[0]), .M0_HTRANS(htrans[0]), .M0_HWRITE(hwrite[0]),
    .M0_HWDATA(hwdata[0]), .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HADDR(haddr[1]), .M1_HSIZE(hsize[1]), .M1_HTRANS(htrans[1]), .M1_HWRITE(hwrite[1]),
    .M1_HWDATA(hwdata[1]), .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .S_HADDR(s_haddr), .S_HSIZE(s_hsize), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite),
    .S_HWDATA(s_hwdata), .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the address bus (-1 = nobody), whether this is the
  // hand-over gap, and which master's transfer is in its data phase (-1 = none).
  int mdl_owner;
  bit mdl_gap;
  int mdl_dp;
  bit mdl_dw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner = int'(RST_OWN);
    mdl_gap   = 1'b0;
    mdl_dp    = -1;
    mdl_dw    = 1'b0;
  endtask

  function automatic bit is_transfer(input logic [1:0] t);
    return (t == NSEQ) || (t == SEQ);
  endfunction

  task automatic model_check();
    int            g;
    bit            gi, di;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_size;
    logic [1:0]    e_trans;
    logic          e_write;
    logic [DW-1:0] e_wdata;
    logic          e_rdy [2];
    logic          e_rsp [2];
    logic [DW-1:0] e_rd  [2];
    g  = (PORESET || mdl_gap) ? -1 : mdl_owner;
    gi = g[0];
    di = mdl_dp[0];
    e_addr = '0; e_size = '0; e_trans = IDLE; e_write = 1'b0;
    if (g >= 0) begin
      e_addr  = haddr[gi];
      e_size  = hsize[gi];
      e_trans = htrans[gi];
      e_write = hwrite[gi];
    end
    e_wdata = (mdl_dp >= 0 && mdl_dw) ? hwdata[di] : '0;
    for (int m = 0; m < 2; m++) begin
      if (PORESET) e_rdy[m] = (m == int'(RST_OWN));
      else         e_rdy[m] = (m == g || m == mdl_dp) ? s_hready : 1'b0;
      e_rsp[m] = (m == mdl_dp) ? s_hresp : 1'b0;
      e_rd[m]  = (m == mdl_dp) ? s_hrdata : '0;
    end
    chk("S_HADDR",   s_haddr,   e_addr);
    chk("S_HSIZE",   s_hsize,   e_size);
    chk("S_HTRANS",  s_htrans,  e_trans);
    chk("S_HWRITE",  s_hwrite,  e_write);
    chk("S_HWDATA",  s_hwdata,  e_wdata);
    chk("M0_HREADY", m0_hready, e_rdy[0]);
    chk("M1_HREADY", m1_hready, e_rdy[1]);
    chk("M0_HRESP",  m0_hresp,  e_rsp[0]);
    chk("M1_HRESP",  m1_hresp,  e_rsp[1]);
    chk("M0_HRDATA", m0_hrdata, e_rd[0]);
    chk("M1_HRDATA", m1_hrdata, e_rd[1]);
  endtask

  task automatic model_update();
    int g, req;
    bit gi;
    if (PORESET) begin
      model_reset();
      return;
    end
    g   = mdl_gap ? -1 : mdl_owner;
    gi  = g[0];
    req = HMSEL[1] ? -1 : int'(HMSEL[0]);
    if (s_hready) begin
      mdl_dp = (g >= 0 && is_transfer(htrans[gi])) ? g : -1;
      mdl_dw = (g >= 0) ? hwrite[gi] : 1'b0;
    end
    if (mdl_gap) begin
      mdl_gap   = 1'b0;
      mdl_owner = req;
    end else if (req != mdl_owner && s_hready &&
                 (mdl_owner < 0 || !is_transfer(htrans[gi]))) begin
      mdl_gap = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge HCLK);
    model_check();
  endtask

  task automatic advance();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    PORESET = 1'b1;
    model_reset();
    settle();
    advance();
    settle();
    advance();
    PORESET = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  hmsel;
    logic [1:0]  t0;
    logic [1:0]  t1;
    logic        rdy;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] hm, input logic [1:0] t0, input logic [1:0] t1,
                              input logic rdy, input logic [1:0] et, input logic [31:0] ea,
                              input logic r0, input logic r1);
    vec_t v;
    v.hmsel = hm; v.t0 = t0; v.t1 = t1; v.rdy = rdy;
    v.e_trans = et; v.e_addr = ea; v.e_r0 = r0; v.e_r1 = r1;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PORESET = 1'b1;
    HMSEL   = 2'b00;
    for (int m = 0; m < 2; m++) begin
      haddr[m] = '0; hsize[m] = 3'b010; htrans[m] = IDLE; hwrite[m] = 1'b0; hwdata[m] = '0;
    end
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;
    model_reset();

    // Cycle table from reset: M0 at 0x1000, M1 at 0x40, reads only.
    tbl[0]  = mk(2'b00, NSEQ, IDLE, 1'b1, NSEQ, 32'h1000, 1'b1, 1'b0);
    tbl[1]  = mk(2'b01, NSEQ, IDLE, 1'b1, NSEQ, 32'h1000, 1'b1, 1'b0);
    tbl[2]  = mk(2'b01, NSEQ, IDLE, 1'b0, NSEQ, 32'h1000, 1'b0, 1'b0);
    tbl[3]  = mk(2'b01, IDLE, IDLE, 1'b0, IDLE, 32'h1000, 1'b0, 1'b0);
    tbl[4]  = mk(2'b01, IDLE, IDLE, 1'b1, IDLE, 32'h1000, 1'b1, 1'b0);
    tbl[5]  = mk(2'b01, NSEQ, NSEQ, 1'b1, IDLE, 32'h0,    1'b0, 1'b0);
    tbl[6]  = mk(2'b01, IDLE, NSEQ, 1'b1, NSEQ, 32'h40,   1'b0, 1'b1);
    tbl[7]  = mk(2'b10, IDLE, IDLE, 1'b1, IDLE, 32'h40,   1'b0, 1'b1);
    tbl[8]  = mk(2'b10, IDLE, IDLE, 1'b1, IDLE, 32'h0,    1'b0, 1'b0);
    tbl[9]  = mk(2'b10, NSEQ, NSEQ, 1'b1, IDLE, 32'h0,    1'b0, 1'b0);
    tbl[10] = mk(2'b00, IDLE, IDLE, 1'b1, IDLE, 32'h0,    1'b0, 1'b0);
    tbl[11] = mk(2'b00, NSEQ, IDLE, 1'b1, IDLE, 32'h0,    1'b0, 1'b0);
    tbl[12] = mk(2'b00, NSEQ, IDLE, 1'b1, NSEQ, 32'h1000, 1'b1, 1'b0);
    tbl[13] = mk(2'b00, IDLE, IDLE, 1'b1, IDLE, 32'h1000, 1'b1, 1'b0);
    tbl[14] = mk(2'b01, NSEQ, IDLE, 1'b1, NSEQ, 32'h1000, 1'b1, 1'b0);
    tbl[15] = mk(2'b00, IDLE, IDLE, 1'b1, IDLE, 32'h1000, 1'b1, 1'b0);
    tbl[16] = mk(2'b00, NSEQ, IDLE, 1'b1, NSEQ, 32'h1000, 1'b1, 1'b0);

    haddr[0] = 32'h1000;
    haddr[1] = 32'h40;
    PORESET = 1'b1;
    model_reset();
    settle();
    chk("RST_S_HTRANS", s_htrans, IDLE);
    chk("RST_S_HADDR", s_haddr, 32'h0);
    chk("RST_M0_HREADY", m0_hready, 1'b1);
    chk("RST_M1_HREADY", m1_hready, 1'b0);
    advance();
    PORESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      HMSEL = tbl[i].hmsel; htrans[0] = tbl[i].t0; htrans[1] = tbl[i].t1; s_hready = tbl[i].rdy;
      settle();
      chk($sformatf("T%0d_S_HTRANS", i), s_htrans, tbl[i].e_trans);
      chk($sformatf("T%0d_S_HADDR", i), s_haddr, tbl[i].e_addr);
      chk($sformatf("T%0d_M0_HREADY", i), m0_hready, tbl[i].e_r0);
      chk($sformatf("T%0d_M1_HREADY", i), m1_hready, tbl[i].e_r1);
      advance();
    end

    // M0 read of 0x1000 with two slave wait states.
    htrans[0] = IDLE; htrans[1] = IDLE; HMSEL = 2'b00; s_hready = 1'b1;
    do_reset();
    htrans[0] = NSEQ; haddr[0] = 32'h1000; hwrite[0] = 1'b0;
    settle();
    chk("A_S_HADDR", s_haddr, 32'h1000);
    advance();
    htrans[0] = IDLE; s_hready = 1'b0;
    settle();
    chk("A_WAIT1_M0_HREADY", m0_hready, 1'b0);
    advance();
    settle();
    chk("A_WAIT2_M0_HREADY", m0_hready, 1'b0);
    chk("A_WAIT2_M1_HREADY", m1_hready, 1'b0);
    advance();
    s_hready = 1'b1; s_hrdata = 32'hDEADBEEF;
    settle();
    chk("A_M0_HRDATA", m0_hrdata, 32'hDEADBEEF);
    chk("A_M0_HREADY", m0_hready, 1'b1);
    chk("A_M1_HREADY", m1_hready, 1'b0);
    advance();

    // Hand-over to M1, then an M1 write of 0x55AA1234 to 0x40.
    HMSEL = 2'b01;
    settle();
    advance();
    settle();
    chk("B_GAP_S_HTRANS", s_htrans, IDLE);
    advance();
    htrans[1] = NSEQ; haddr[1] = 32'h40; hwrite[1] = 1'b1;
    settle();
    chk("B_S_HADDR", s_haddr, 32'h40);
    chk("B_M1_HREADY", m1_hready, 1'b1);
    advance();
    htrans[1] = IDLE; hwdata[1] = 32'h55AA1234; hwdata[0] = 32'hFFFFFFFF;
    settle();
    chk("B_S_HWDATA", s_hwdata, 32'h55AA1234);
    advance();

    // Two-cycle ERROR response to an M1 read.
    htrans[1] = NSEQ; haddr[1] = 32'h44; hwrite[1] = 1'b0;
    settle();
    advance();
    htrans[1] = IDLE; s_hready = 1'b0; s_hresp = 1'b1;
    settle();
    chk("C1_M1_HRESP", m1_hresp, 1'b1);
    chk("C1_M1_HREADY", m1_hready, 1'b0);
    chk("C1_M0_HRESP", m0_hresp, 1'b0);
    advance();
    s_hready = 1'b1;
    settle();
    chk("C2_M1_HRESP", m1_hresp, 1'b1);
    chk("C2_M1_HREADY", m1_hready, 1'b1);
    chk("C2_M0_HRESP", m0_hresp, 1'b0);
    advance();
    s_hresp = 1'b0;

    // Reset asserted during the data phase of an M1 write.
    htrans[1] = NSEQ; haddr[1] = 32'h48; hwrite[1] = 1'b1;
    settle();
    advance();
    hwdata[1] = 32'h12345678;
    PORESET = 1'b1;
    model_reset();
    #1;
    chk("D_S_HTRANS", s_htrans, IDLE);
    chk("D_S_HWDATA", s_hwdata, 32'h0);
    chk("D_M0_HREADY", m0_hready, 1'b1);
    chk("D_M1_HREADY", m1_hready, 1'b0);
    settle();
    advance();
    PORESET = 1'b0;
    htrans[0] = NSEQ; haddr[0] = 32'h2000; hwrite[0] = 1'b0;
    settle();
    chk("D_POST_S_HADDR", s_haddr, 32'h2000);
    chk("D_POST_M0_HREADY", m0_hready, 1'b1);
    chk("D_POST_M1_HREADY", m1_hready, 1'b0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) HMSEL = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        htrans[m] = 2'($urandom);
        haddr[m]  = $urandom;
        hsize[m]  = 3'($urandom);
        hwrite[m] = 1'($urandom);
        hwdata[m] = $urandom;
      end
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = ($urandom_range(0, 9) == 0);
      s_hrdata = $urandom;
      PORESET  = ($urandom_range(0, 399) == 0);
      if (PORESET) model_reset();
      settle();
      advance();
    end
    PORESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_mux.md
Name: ahb_master_mux

Overview:
- Two-master AHB-lite multiplexer between the SoC core master (master 0) and the UART bridge master (master 1) on one shared AHB-lite slave bus.
- Ownership follows the HMSEL select produced by the UART bridge.
- Switches occur only at safe transfer boundaries, with one inserted IDLE cycle.
- Tracks the data-phase owner so HWDATA, HRDATA, HREADY and HRESP are routed to the correct master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RESET_OWNER, 0, master granted out of reset (0 or 1)

Ports:
HCLK  input  1  bus clock
PORESET  input  1  asynchronous active-high reset
HMSEL  input  2  owner select: 00 = master 0, 01 = master 1, 1x = no master
M0_HADDR / M1_HADDR  input  ADDR_W  master address
M0_HSIZE / M1_HSIZE  input  3  master transfer size
M0_HTRANS / M1_HTRANS  input  2  master transfer type
M0_HWRITE / M1_HWRITE  input  1  master write control
M0_HWDATA / M1_HWDATA  input  DATA_W  master write data
M0_HRDATA / M1_HRDATA  output  DATA_W  read data to master
M0_HREADY / M1_HREADY  output  1  ready to master
M0_HRESP / M1_HRESP  output  1  response to master
S_HADDR  output  ADDR_W  slave-bus address
S_HSIZE  output  3  slave-bus size
S_HTRANS  output  2  slave-bus transfer type
S_HWRITE  output  1  slave-bus write control
S_HWDATA  output  DATA_W  slave-bus write data
S_HRDATA  input  DATA_W  slave read data
S_HREADY  input  1  slave ready
S_HRESP  input  1  slave response

Behaviour:
- Clocking and reset: one clock, HCLK. PORESET is asynchronous, active-high. All state clears immediately on assertion.
- State machine: OWN0, OWN1, NONE, GAP. Registers: aowner (address-phase owner) and downer/dvalid (data-phase owner and valid flag).
- Reset state: OWN<RESET_OWNER>, dvalid=0.
- Reset output values:
  - S_HTRANS=IDLE(00); S_HADDR, S_HSIZE, S_HWRITE, S_HWDATA = 0.
  - Granted master: HREADY=1. Other master: HREADY=0.
  - All HRESP=0; all HRDATA=0.
- Request decode: req = 0 for HMSEL 00, 1 for 01, NONE for 1x.
- OWNx address phase: owner's HADDR, HSIZE, HTRANS and HWRITE pass combinationally to S_* (zero latency). Owner HREADY = S_HREADY.
- Non-owner: HREADY=0 (stalled), HRESP=0, HRDATA=0.
- NONE and GAP: S_HTRANS=IDLE, S_HADDR/S_HSIZE/S_HWRITE=0. Both master HREADY=0, except that the data-phase owner still gets S_HREADY while dvalid=1.
- Data-phase tracking: on every HCLK edge with S_HREADY=1:
  - dvalid <= (address-phase HTRANS is NONSEQ or SEQ);
  - downer <= aowner;
  - dwrite <= S_HWRITE.
- Data-phase routing:
  - S_HWDATA = downer's HWDATA when dvalid && dwrite, else 0.
  - S_HRDATA and S_HRESP are forwarded to downer's HRDATA/HRESP while dvalid=1.
- Two-cycle ERROR response (HRESP=1 with HREADY 0 then 1) passes through unmodified to downer.
- Switch from OWNx:
  - Trigger: req != x and S_HREADY=1 and the owner's HTRANS is IDLE or BUSY.
  - Transition: go to GAP at that edge.
- GAP lasts exactly 1 cycle, then goes to OWN<req> or NONE per req sampled in GAP.
- If req returns to x before the switch condition is met, no switch occurs and no GAP is inserted.
- While the owner keeps issuing NONSEQ/SEQ, the switch is deferred indefinitely. This is the required behaviour, since a granted address phase is never aborted.
- NONE: on req != NONE, go to GAP, then OWN<req>.
- Simultaneous events: a new request arriving in the same cycle as S_HREADY=0 is held until S_HREADY=1. HMSEL changes during GAP are resolved using the value sampled in GAP.
- Reset mid-transfer: the pending data phase is dropped (dvalid=0) and the slave sees IDLE immediately. The slave is expected to share PORESET.

Test Plan:
- Reset with RESET_OWNER=0, HMSEL=00, M0 NONSEQ read 0x0000_1000, slave returns 0xDEADBEEF after 2 wait states -> S_HADDR=0x1000 same cycle; M0_HRDATA=0xDEADBEEF with M0_HREADY high on third data cycle; M1_HREADY stays 0.
- HMSEL 00->01 while M0 issues back-to-back NONSEQ writes, M0 then goes IDLE -> no switch until M0 IDLE at a S_HREADY=1 edge; exactly one GAP cycle with S_HTRANS=IDLE; then M1_HREADY=1 and M1 addresses reach S_HADDR.
- M1 write 0x55AA_1234 to 0x40 immediately after switch -> S_HWDATA=0x55AA1234 in data phase, sourced from M1 only; M0_HWDATA ignored.
- Slave ERROR response to M1 read (HRESP=1 with HREADY 0 then 1) -> M1_HRESP=1 for both cycles, M1_HREADY 0 then 1; M0_HRESP stays 0.
- HMSEL=10 while M1 IDLE -> GAP then NONE: S_HTRANS=00, both HREADY=0; HMSEL=00 -> GAP, then OWN0 with M0_HREADY=1.
- PORESET asserted mid data phase of M1 write -> same-cycle S_HTRANS=IDLE, S_HWDATA=0, dvalid cleared; after release, owner is RESET_OWNER.
